// File: rtl/posdata_pkg.sv
// Shared types and helpers for the position-data packet serializer.
// State encoding, default header byte and payload byte-count helper.
package posdata_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PAY  = 2'd2,
        CHK  = 2'd3
    } ser_state_t;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Payload bytes needed to carry a {position, frame} word.
    function automatic int num_bytes(input int p, input int f);
        return (p + f + 7) / 8;
    endfunction

endpackage

// File: rtl/posdata_packet_serializer.sv
// Frames each new {position, frame} word as header + MSB-first payload (+ checksum)
// over a valid/ready byte stream. Checksum byte is built only with POSDATA_CHECKSUM_EN.
module posdata_packet_serializer
    import posdata_pkg::*;
#(
    parameter int         POSTI_BIT_WIDTH = 16,
    parameter int         FRAME_BIT_WIDTH = 16,
    parameter logic [7:0] HEADER_BYTE     = HEADER_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     n_rst,
    input  logic                                     enable,
    input  logic [FRAME_BIT_WIDTH-1:0]               frameNum,
    input  logic [POSTI_BIT_WIDTH+FRAME_BIT_WIDTH-1:0] sendData,
    output logic [7:0]                               tx_data,
    output logic                                     tx_valid,
    input  logic                                     tx_ready,
    output logic                                     pkt_done,
    output logic                                     busy,
    output logic [15:0]                              drop_cnt
);

    localparam int NUM_BYTES = num_bytes(POSTI_BIT_WIDTH, FRAME_BIT_WIDTH);
    localparam int PAY_W     = NUM_BYTES * 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    function automatic logic [7:0] twos_neg8(input logic [7:0] v);
        logic signed [7:0] s;
        s = -$signed(v);
        return $unsigned(s);
    endfunction

    ser_state_t                 state;
    ser_state_t                 next_state;
    logic [FRAME_BIT_WIDTH-1:0] frame_d;
    logic [PAY_W-1:0]           shreg;
    logic [IDX_W-1:0]           idx;
`ifdef POSDATA_CHECKSUM_EN
    logic [7:0]                 acc;
`endif

    logic new_frame;
    logic accept;
    logic last_accept;
    logic capture;
    logic drop;

    assign new_frame = (frameNum != frame_d);
    assign accept    = tx_valid && tx_ready;
`ifdef POSDATA_CHECKSUM_EN
    assign last_accept = accept && (state == CHK);
`else
    assign last_accept = accept && (state == PAY) && (idx == '0);
`endif
    assign capture = new_frame && enable && ((state == IDLE) || last_accept);
    assign drop    = new_frame && enable && !capture;

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; capture only ever fires in IDLE or on the final handshake.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (capture) next_state = HDR;
            end
            HDR: begin
                if (accept) next_state = PAY;
            end
            PAY: begin
                if (accept && (idx == '0)) begin
`ifdef POSDATA_CHECKSUM_EN
                    next_state = CHK;
`else
                    next_state = capture ? HDR : IDLE;
`endif
                end
            end
`ifdef POSDATA_CHECKSUM_EN
            CHK: begin
                if (accept) next_state = capture ? HDR : IDLE;
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        busy     = (state != IDLE);
        case (state)
            HDR: begin
                tx_valid = 1'b1;
                tx_data  = HEADER_BYTE;
            end
            PAY: begin
                tx_valid = 1'b1;
                tx_data  = shreg[PAY_W-1 -: 8];
            end
`ifdef POSDATA_CHECKSUM_EN
            CHK: begin
                tx_valid = 1'b1;
                tx_data  = twos_neg8(acc);
            end
`endif
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    // Payload shift register and byte index; a capture reloads even mid-handshake.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            frame_d <= '0;
            shreg   <= '0;
            idx     <= '0;
        end else begin
            frame_d <= frameNum;
            if (capture) begin
                shreg <= PAY_W'(sendData);
            end else if (accept && (state == PAY)) begin
                shreg <= shreg << 8;
            end
            if (accept && (state == HDR)) begin
                idx <= IDX_W'(NUM_BYTES - 1);
            end else if (accept && (state == PAY) && (idx != '0)) begin
                idx <= idx - 1'b1;
            end
        end
    end

`ifdef POSDATA_CHECKSUM_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc <= 8'h00;
        end else if (capture) begin
            acc <= 8'h00;
        end else if (accept) begin
            acc <= acc + tx_data;
        end
    end
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_done <= 1'b0;
            drop_cnt <= 16'h0000;
        end else begin
            pkt_done <= last_accept;
            if (drop) drop_cnt <= sat_inc16(drop_cnt);
        end
    end

endmodule

// File: tb/tb_posdata_packet_serializer.sv
// Directed bench for posdata_packet_serializer (P=16, F=16).
// Expected byte streams adapt to POSDATA_CHECKSUM_EN.
module tb_posdata_packet_serializer;

`ifdef POSDATA_CHECKSUM_EN
    localparam int PKT_LEN = 6;
`else
    localparam int PKT_LEN = 5;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] frameNum = 16'h0000;
    logic [31:0] sendData = 32'h0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        pkt_done;
    logic        busy;
    logic [15:0] drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         pd_cnt = 0;
    int         stall_err = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         rdy_mode = 0;
    int         pat_i = 0;

    posdata_packet_serializer dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .enable   (enable),
        .frameNum (frameNum),
        .sendData (sendData),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .pkt_done (pkt_done),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // tx_ready driver: 0 = always ready, 1 = 1-0-0-1 then random, 2 = never ready
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                case (pat_i)
                    0: tx_ready <= 1'b1;
                    1: tx_ready <= 1'b0;
                    2: tx_ready <= 1'b0;
                    3: tx_ready <= 1'b1;
                    default: tx_ready <= 1'($urandom_range(0, 1));
                endcase
                pat_i <= pat_i + 1;
            end
            2: begin
                tx_ready <= 1'b0;
                pat_i    <= 0;
            end
            default: begin
                tx_ready <= 1'b1;
                pat_i    <= 0;
            end
        endcase
    end

    // Byte / pulse / stall-stability monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (n_rst) begin
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (pkt_done) pd_cnt <= pd_cnt + 1;
            if (prev_stall && (!tx_valid || (tx_data !== prev_data))) stall_err <= stall_err + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input logic [15:0] fn, input logic [31:0] sd);
        frameNum = fn;
        sendData = sd;
    endtask

    task automatic wait_bytes(input string tag, input int base, input int n);
        int k;
        k = 0;
        while ((got_q.size() < base + n) && (k < 400)) begin
            cycle();
            k++;
        end
        repeat (3) cycle();
        check({tag, "_nbytes"}, 32'(got_q.size() - base), 32'(n));
    endtask

    task automatic check_bytes(input string tag, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_b%0d", tag, i), {24'h0, got_q[base + i]}, {24'h0, exp_q[i]});
            else
                check($sformatf("%s_b%0d_missing", tag, i), 32'(got_q.size()), 32'(base + i + 1));
        end
    endtask

    task automatic exp_1234();
        exp_q = {8'hA5, 8'h12, 8'h34, 8'h00, 8'h05};
`ifdef POSDATA_CHECKSUM_EN
        exp_q.push_back(8'h10);
`endif
    endtask

    task automatic exp_ffff();
        exp_q = {8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h01};
`ifdef POSDATA_CHECKSUM_EN
        exp_q.push_back(8'h5C);
`endif
    endtask

    task automatic exp_cafe();
        exp_q = {8'hA5, 8'hCA, 8'hFE, 8'h00, 8'h03};
`ifdef POSDATA_CHECKSUM_EN
        exp_q.push_back(8'h90);
`endif
    endtask

    initial begin
        int base;
        int pd0;
        logic [7:0] both[$];

        // Reset state
        #3;
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_pkt_done", {31'h0, pkt_done}, 32'h0);
        check("rst_drop_cnt", {16'h0, drop_cnt}, 32'h0);
        cycle();
        n_rst = 1'b1;
        repeat (3) cycle();
        check("idle_no_spurious", {31'h0, tx_valid}, 32'h0);

        // T1: basic packet, always ready, header one cycle after the frame change
        base = got_q.size();
        pd0  = pd_cnt;
        drive_frame(16'd1, 32'h1234_0005);
        check("t1_pre_valid", {31'h0, tx_valid}, 32'h0);
        cycle();
        check("t1_hdr_valid", {31'h0, tx_valid}, 32'h1);
        check("t1_hdr_data", {24'h0, tx_data}, 32'hA5);
        wait_bytes("t1", base, PKT_LEN);
        exp_1234();
        check_bytes("t1", base);
        check("t1_pkt_done", 32'(pd_cnt - pd0), 32'd1);
        check("t1_drop", {16'h0, drop_cnt}, 32'h0);

        // T2: same packet with stalls
        rdy_mode = 1;
        cycle();
        base = got_q.size();
        pd0  = pd_cnt;
        drive_frame(16'd2, 32'h1234_0005);
        wait_bytes("t2", base, PKT_LEN);
        check_bytes("t2", base);
        check("t2_pkt_done", 32'(pd_cnt - pd0), 32'd1);
        check("t2_stall_hold", 32'(stall_err), 32'd0);
        rdy_mode = 0;
        repeat (2) cycle();

        // T3: second frame change during PAY is dropped
        base = got_q.size();
        pd0  = pd_cnt;
        drive_frame(16'd3, 32'hCAFE_0003);
        cycle();
        cycle();
        check("t3_in_pay", {31'h0, busy}, 32'h1);
        drive_frame(16'd4, 32'h9999_8888);
        wait_bytes("t3", base, PKT_LEN);
        exp_cafe();
        check_bytes("t3", base);
        repeat (20) cycle();
        check("t3_no_second_pkt", 32'(got_q.size() - base), 32'(PKT_LEN));
        check("t3_drop", {16'h0, drop_cnt}, 32'h1);
        check("t3_idle", {31'h0, busy}, 32'h0);
        check("t3_pkt_done", 32'(pd_cnt - pd0), 32'd1);

        // T4: new frame in the cycle the final byte is accepted
        base = got_q.size();
        pd0  = pd_cnt;
        drive_frame(16'd5, 32'h1234_0005);
        repeat (PKT_LEN) cycle();
        drive_frame(16'd6, 32'hFFFF_0001);
        cycle();
        check("t4_next_hdr_valid", {31'h0, tx_valid}, 32'h1);
        check("t4_next_hdr_data", {24'h0, tx_data}, 32'hA5);
        wait_bytes("t4", base, 2 * PKT_LEN);
        exp_1234();
        both = exp_q;
        exp_ffff();
        exp_q = {both, exp_q};
        check_bytes("t4", base);
        check("t4_drop", {16'h0, drop_cnt}, 32'h1);
        check("t4_pkt_done", 32'(pd_cnt - pd0), 32'd2);

        // T5: enable low ignores frames; async reset mid-packet
        n_rst = 1'b0;
        drive_frame(16'd0, 32'h0);
        cycle();
        n_rst = 1'b1;
        cycle();
        check("t5_drop_cleared", {16'h0, drop_cnt}, 32'h0);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_frame(16'(20 + i), 32'hABCD_0000 + 32'(i));
            cycle();
            check($sformatf("t5_dis_valid%0d", i), {31'h0, tx_valid}, 32'h0);
        end
        cycle();
        check("t5_dis_valid_end", {31'h0, tx_valid}, 32'h0);
        check("t5_dis_drop", {16'h0, drop_cnt}, 32'h0);
        enable = 1'b1;
        cycle();
        drive_frame(16'd30, 32'h1111_2222);
        cycle();
        cycle();
        check("t5_pay_valid", {31'h0, tx_valid}, 32'h1);
        #2;
        n_rst = 1'b0;
        #1;
        check("t5_rst_valid", {31'h0, tx_valid}, 32'h0);
        check("t5_rst_busy", {31'h0, busy}, 32'h0);
        drive_frame(16'd0, 32'h0);
        cycle();
        n_rst = 1'b1;
        repeat (3) cycle();
        check("t5_post_rst_valid", {31'h0, tx_valid}, 32'h0);

        // T6: all-ones position field
        base = got_q.size();
        pd0  = pd_cnt;
        drive_frame(16'd7, 32'hFFFF_0001);
        wait_bytes("t6", base, PKT_LEN);
        exp_ffff();
        check_bytes("t6", base);
        check("t6_pkt_done", 32'(pd_cnt - pd0), 32'd1);

        // T7: drop counter saturation while the sink stalls
        rdy_mode = 2;
        repeat (2) cycle();
        drive_frame(16'd100, 32'h5555_AAAA);
        cycle();
        check("t7_hdr_valid", {31'h0, tx_valid}, 32'h1);
        for (int i = 0; i < 65537; i++) begin
            frameNum = frameNum + 16'd1;
            cycle();
            if (i == 999) check("t7_drop_1000", {16'h0, drop_cnt}, 32'd1000);
            if (i == 65534) check("t7_drop_65535", {16'h0, drop_cnt}, 32'hFFFF);
        end
        check("t7_drop_sat", {16'h0, drop_cnt}, 32'hFFFF);
        check("t7_hdr_held", {24'h0, tx_data}, 32'hA5);
        check("t7_stall_hold", 32'(stall_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
